// File: rtl/drbg_pkg.sv
// ---------------------------------------------------------------------------
// drbg_pkg
//   Shared widths, the generate-engine state encoding and the default reseed
//   interval for the CTR_DRBG blocks.
// ---------------------------------------------------------------------------
package drbg_pkg;

   localparam int KEY_W  = 256;  // AES-256 key
   localparam int BLK_W  = 128;  // cipher block / V width
   localparam int SEED_W = 384;  // seedlen = KEY_W + BLK_W

   // 2**48 generate calls are allowed between reseeds
   localparam logic [63:0] RESEED_INTERVAL_DEF = 64'h0001_0000_0000_0000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CHECK,
      ST_UPD_PRE,
      ST_WAIT_PRE,
      ST_ENC,
      ST_WAIT_ENC,
      ST_OUT,
      ST_UPD_POST,
      ST_WAIT_POST,
      ST_FINISH
   } gen_state_t;

endpackage

// File: rtl/ctr_drbg_generate.sv
// ---------------------------------------------------------------------------
// ctr_drbg_generate
//   CTR_DRBG generate engine (no derivation function). Accepts one generate
//   request, optionally folds the additional input in through the update
//   block, produces nblocks cipher blocks of E(Key, ++V) one at a time through
//   a single-entry output buffer, runs the closing update and returns the new
//   Key, V and reseed counter with a one-cycle done pulse.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   req_*               generate request (valid/ready), Key/V/ctr snapshot
//   enc_*               block cipher request/done handshake
//   upd_*               CTR_DRBG update request/done handshake
//   out_*               output block stream (valid/ready), out_last on final
//   done, reseed_required, key_out, v_out, reseed_ctr_out
//                       completion status and returned working state
// ---------------------------------------------------------------------------
module ctr_drbg_generate
   import drbg_pkg::*;
#(
   parameter int               NB_W            = 16,
   parameter int               CTR_W           = 49,
   parameter logic [CTR_W-1:0] RESEED_INTERVAL = CTR_W'(RESEED_INTERVAL_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   // request
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [NB_W-1:0]     req_nblocks,
   input  logic [SEED_W-1:0]   req_addl,
   input  logic [KEY_W-1:0]    key_in,
   input  logic [BLK_W-1:0]    v_in,
   input  logic [CTR_W-1:0]    reseed_ctr_in,
   // block cipher
   output logic                enc_start,
   output logic [KEY_W-1:0]    enc_key,
   output logic [BLK_W-1:0]    enc_pt,
   input  logic                enc_done,
   input  logic [BLK_W-1:0]    enc_ct,
   // update block
   output logic                upd_start,
   output logic [SEED_W-1:0]   upd_data,
   output logic [KEY_W-1:0]    upd_key,
   output logic [BLK_W-1:0]    upd_v,
   input  logic                upd_done,
   input  logic [KEY_W-1:0]    upd_key_out,
   input  logic [BLK_W-1:0]    upd_v_out,
   // output stream
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BLK_W-1:0]    out_data,
   output logic                out_last,
   // completion
   output logic                done,
   output logic                reseed_required,
   output logic [KEY_W-1:0]    key_out,
   output logic [BLK_W-1:0]    v_out,
   output logic [CTR_W-1:0]    reseed_ctr_out
);

   gen_state_t        state_q, state_d;

   logic [NB_W-1:0]   nblk_q,      nblk_d;       // blocks still to deliver
   logic [SEED_W-1:0] addl_q,      addl_d;
   logic [KEY_W-1:0]  key_q,       key_d;
   logic [BLK_W-1:0]  v_q,         v_d;
   logic [CTR_W-1:0]  ctr_q,       ctr_d;
   logic              enc_start_q, enc_start_d;
   logic              upd_start_q, upd_start_d;
   logic              ovalid_q,    ovalid_d;
   logic [BLK_W-1:0]  odata_q,     odata_d;
   logic              olast_q,     olast_d;
   logic              rr_q,        rr_d;
   logic [KEY_W-1:0]  key_out_q,   key_out_d;
   logic [BLK_W-1:0]  v_out_q,     v_out_d;
   logic [CTR_W-1:0]  ctr_out_q,   ctr_out_d;

   logic              refuse;
   logic              last_blk;

   assign refuse   = (ctr_q > RESEED_INTERVAL);
   assign last_blk = (nblk_q == NB_W'(1));

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (req_valid) state_d = ST_CHECK;
         ST_CHECK: begin
            if (refuse)               state_d = ST_FINISH;
            else if (addl_q != '0)    state_d = ST_UPD_PRE;
            else if (nblk_q == '0)    state_d = ST_UPD_POST;
            else                      state_d = ST_ENC;
         end
         ST_UPD_PRE:   state_d = ST_WAIT_PRE;
         ST_WAIT_PRE:  if (upd_done) state_d = (nblk_q == '0) ? ST_UPD_POST : ST_ENC;
         ST_ENC:       state_d = ST_WAIT_ENC;
         ST_WAIT_ENC:  if (enc_done) state_d = ST_OUT;
         ST_OUT:       if (out_ready) state_d = last_blk ? ST_UPD_POST : ST_ENC;
         ST_UPD_POST:  state_d = ST_WAIT_POST;
         ST_WAIT_POST: if (upd_done) state_d = ST_FINISH;
         ST_FINISH:    state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- state outputs
   always_comb begin
      req_ready       = (state_q == ST_IDLE);
      done            = (state_q == ST_FINISH);
      reseed_required = (state_q == ST_FINISH) && rr_q;
   end

   // ---------------------------------------------------------------- datapath
   always_comb begin
      nblk_d      = nblk_q;
      addl_d      = addl_q;
      key_d       = key_q;
      v_d         = v_q;
      ctr_d       = ctr_q;
      enc_start_d = 1'b0;
      upd_start_d = 1'b0;
      ovalid_d    = ovalid_q;
      odata_d     = odata_q;
      olast_d     = olast_q;
      rr_d        = rr_q;
      key_out_d   = key_out_q;
      v_out_d     = v_out_q;
      ctr_out_d   = ctr_out_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               nblk_d = req_nblocks;
               addl_d = req_addl;
               key_d  = key_in;
               v_d    = v_in;
               ctr_d  = reseed_ctr_in;
            end
         end
         ST_CHECK: begin
            rr_d = refuse;
            // a refused request hands the working state back untouched
            if (refuse) begin
               key_out_d = key_q;
               v_out_d   = v_q;
               ctr_out_d = ctr_q;
            end
         end
         ST_UPD_PRE:  upd_start_d = 1'b1;
         ST_WAIT_PRE: begin
            if (upd_done) begin
               key_d = upd_key_out;
               v_d   = upd_v_out;
            end
         end
         ST_ENC: begin
            // pre-increment: the cipher sees V+1, and V keeps that value
            v_d         = v_q + BLK_W'(1);
            enc_start_d = 1'b1;
         end
         ST_WAIT_ENC: begin
            if (enc_done) begin
               ovalid_d = 1'b1;
               odata_d  = enc_ct;
               olast_d  = last_blk;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               olast_d  = 1'b0;
               nblk_d   = nblk_q - NB_W'(1);
            end
         end
         ST_UPD_POST: upd_start_d = 1'b1;
         ST_WAIT_POST: begin
            if (upd_done) begin
               key_d     = upd_key_out;
               v_d       = upd_v_out;
               key_out_d = upd_key_out;
               v_out_d   = upd_v_out;
               ctr_out_d = ctr_q + CTR_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         nblk_q      <= '0;
         addl_q      <= '0;
         key_q       <= '0;
         v_q         <= '0;
         ctr_q       <= '0;
         enc_start_q <= 1'b0;
         upd_start_q <= 1'b0;
         ovalid_q    <= 1'b0;
         odata_q     <= '0;
         olast_q     <= 1'b0;
         rr_q        <= 1'b0;
         key_out_q   <= '0;
         v_out_q     <= '0;
         ctr_out_q   <= '0;
      end else begin
         nblk_q      <= nblk_d;
         addl_q      <= addl_d;
         key_q       <= key_d;
         v_q         <= v_d;
         ctr_q       <= ctr_d;
         enc_start_q <= enc_start_d;
         upd_start_q <= upd_start_d;
         ovalid_q    <= ovalid_d;
         odata_q     <= odata_d;
         olast_q     <= olast_d;
         rr_q        <= rr_d;
         key_out_q   <= key_out_d;
         v_out_q     <= v_out_d;
         ctr_out_q   <= ctr_out_d;
      end
   end

   // key_q/v_q/addl_q only move on the done handshakes, so the cipher and
   // update operands stay stable for the whole wait.
   assign enc_start      = enc_start_q;
   assign enc_key        = key_q;
   assign enc_pt         = v_q;
   assign upd_start      = upd_start_q;
   assign upd_data       = addl_q;
   assign upd_key        = key_q;
   assign upd_v          = v_q;
   assign out_valid      = ovalid_q;
   assign out_data       = odata_q;
   assign out_last       = olast_q;
   assign key_out        = key_out_q;
   assign v_out          = v_out_q;
   assign reseed_ctr_out = ctr_out_q;

endmodule
